// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the two-client RAM arbiter.
// Holds the address/data width defaults and the arbiter FSM states.
package ram_arbiter_pkg;

  localparam int ADDR_W_DFLT = 3;
  localparam int DATA_W_DFLT = 8;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer.
// Ports: clk, rst_n, en_i (grant allowed), req_i[1:0], gnt_o[1:0] one-hot0.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 1 = requester 1 (B) won last, so requester 0 (A) is favoured
  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    // every grant is a transfer since gnt only follows req
    last_d = (|gnt_o) ? gnt_o[1] : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two clients onto one external RAM port, with a zero-fill clear.
// Ports: client A/B req/we/addr/wdata -> gnt/rvalid, shared rdata;
// clr_start -> busy/clr_done; mem_* drive an external 1-cycle-latency RAM.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  output logic              mem_wr_enb,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd_enb,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        gnt;
  logic              arb_en;

  // rst_n gates grants so reset silences gnt/mem_* at once
  assign arb_en = rst_n & (state_q == ARB) & ~clr_start;

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (arb_en),
    .req_i ({b_req, a_req}),
    .gnt_o (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy        = 1'b0;
    clr_done    = 1'b0;
    mem_wr_enb  = 1'b0;
    mem_wr_addr = '0;
    mem_data_in = '0;
    mem_rd_enb  = 1'b0;
    mem_rd_addr = '0;
    unique case (state_q)
      ARB: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
        unique case (1'b1)
          gnt[0]: begin
            if (a_we) begin
              mem_wr_enb  = 1'b1;
              mem_wr_addr = a_addr;
              mem_data_in = a_wdata;
            end else begin
              mem_rd_enb  = 1'b1;
              mem_rd_addr = a_addr;
            end
          end
          gnt[1]: begin
            if (b_we) begin
              mem_wr_enb  = 1'b1;
              mem_wr_addr = b_addr;
              mem_data_in = b_wdata;
            end else begin
              mem_rd_enb  = 1'b1;
              mem_rd_addr = b_addr;
            end
          end
          default: ;
        endcase
      end
      CLEAR: begin
        busy        = 1'b1;
        mem_wr_enb  = 1'b1;
        mem_wr_addr = cnt_q;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          clr_done = 1'b1;
          state_d  = ARB;
          cnt_d    = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // read completion is tracked independently of the FSM so a read
  // issued just before a clear still returns its data
  assign rvalid_d = {gnt[1] & ~b_we, gnt[0] & ~a_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign a_rvalid = rvalid_q[0];
  assign b_rvalid = rvalid_q[1];
  assign rdata    = (|rvalid_q) ? mem_data_out : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural 8x8 RAM.
// Read results are scoreboarded and compared when rvalid appears.
module tb_ram_arbiter;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] rdata;
  logic          clr_start = 0;
  logic          busy, clr_done;
  logic          mem_wr_enb, mem_rd_enb;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  typedef struct {
    logic          own_b;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [8];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_gnt        (a_gnt),
    .a_rvalid     (a_rvalid),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_gnt        (b_gnt),
    .b_rvalid     (b_rvalid),
    .rdata        (rdata),
    .clr_start    (clr_start),
    .busy         (busy),
    .clr_done     (clr_done),
    .mem_wr_enb   (mem_wr_enb),
    .mem_wr_addr  (mem_wr_addr),
    .mem_data_in  (mem_data_in),
    .mem_rd_enb   (mem_rd_enb),
    .mem_rd_addr  (mem_rd_addr),
    .mem_data_out (mem_data_out)
  );

  logic [DW-1:0] ram [8] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_data_out <= '0;
    end else begin
      if (mem_wr_enb) ram[mem_wr_addr] <= mem_data_in;
      if (mem_rd_enb) mem_data_out <= ram[mem_rd_addr];
    end
  end

  function automatic logic [29:0] outs();
    return {a_gnt, b_gnt, a_rvalid, b_rvalid, busy, clr_done,
            mem_wr_enb, mem_rd_enb, mem_wr_addr, mem_data_in,
            mem_rd_addr, rdata};
  endfunction

  // record the expected effect of a grant the bench expects
  task automatic issue(input logic ga, input logic gb);
    if (ga) begin
      if (a_we) ref_mem[a_addr] = a_wdata;
      else sb.push_back('{own_b: 1'b0, data: ref_mem[a_addr], due: cyc + 1});
    end
    if (gb) begin
      if (b_we) ref_mem[b_addr] = b_wdata;
      else sb.push_back('{own_b: 1'b1, data: ref_mem[b_addr], due: cyc + 1});
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          n_chk++;
          if ({b_rvalid, a_rvalid} !== {e.own_b, ~e.own_b} || rdata !== e.data) begin
            n_fail++;
            $display("FAIL rvalid cyc=%0d got b/a=%b%b rdata=%h want b/a=%b%b rdata=%h",
                     cyc, b_rvalid, a_rvalid, rdata, e.own_b, ~e.own_b, e.data);
          end
        end else if (a_rvalid || b_rvalid) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_rvalid cyc=%0d got b/a=%b%b want 00",
                   cyc, b_rvalid, a_rvalid);
        end
      end
    end
  endtask

  task automatic do_reset();
    a_req = 0; b_req = 0; clr_start = 0;
    rst_n = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1;
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    #2 rst_n = 0;
    #1;
    n_chk++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_now got %h want 0", outs());
    end
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_hold got %h want 0", outs());
    end
    a_req = 0; b_req = 0;
    @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    n_chk++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset got %h want 0", outs());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] wd [2];
    wd[0] = 8'h11;
    wd[1] = 8'h22;
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = 8'h5A;
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt} !== 2'b10 ||
        {mem_wr_enb, mem_rd_enb, mem_wr_addr, mem_data_in} !== {2'b10, 3'd3, 8'h5A}) begin
      n_fail++;
      $display("FAIL a_write got gnt=%b%b wr=%b rd=%b wa=%0d wd=%h want 10 1 0 3 5a",
               a_gnt, b_gnt, mem_wr_enb, mem_rd_enb, mem_wr_addr, mem_data_in);
    end
    issue(1, 0);
    @(posedge clk); #1;
    a_we = 0;
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt} !== 2'b10 ||
        {mem_wr_enb, mem_rd_enb, mem_rd_addr} !== {2'b01, 3'd3}) begin
      n_fail++;
      $display("FAIL a_read got gnt=%b%b wr=%b rd=%b ra=%0d want 10 0 1 3",
               a_gnt, b_gnt, mem_wr_enb, mem_rd_enb, mem_rd_addr);
    end
    issue(1, 0);
    @(posedge clk); #1;
    a_req = 0;
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt, mem_wr_enb, mem_rd_enb, mem_wr_addr,
         mem_data_in, mem_rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL idle_mem got gnt=%b%b wr=%b rd=%b want all 0",
               a_gnt, b_gnt, mem_wr_enb, mem_rd_enb);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      a_req = 1; a_we = 1; a_addr = AW'(i + 1); a_wdata = wd[i];
      @(negedge clk);
      n_chk++;
      if ({a_gnt, b_gnt} !== 2'b10) begin
        n_fail++;
        $display("FAIL fill_write got %b%b want 10", a_gnt, b_gnt);
      end
      issue(1, 0);
      @(posedge clk); #1;
    end
    a_req = 0; a_we = 0;
  endtask

  task automatic test_alternate();
    logic [1:0] exp;
    a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 1; b_addr = 2;
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      n_chk++;
      if ({a_gnt, b_gnt} !== exp) begin
        n_fail++;
        $display("FAIL alternate[%0d] got %b%b want %b", i, a_gnt, b_gnt, exp);
      end
      issue(exp[1], exp[0]);
      @(posedge clk); #1;
    end
    a_req = 0; b_req = 0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_b_write_a_read();
    b_req = 1; b_we = 1; b_addr = 6; b_wdata = 8'hC3;
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL b_write got %b%b want 01", a_gnt, b_gnt);
    end
    issue(0, 1);
    @(posedge clk); #1;
    b_req = 0; b_we = 0; a_req = 1; a_we = 0; a_addr = 6;
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL a_read_after_b got %b%b want 10", a_gnt, b_gnt);
    end
    issue(1, 0);
    @(posedge clk); #1;
    a_req = 0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_starve();
    b_req = 1; b_we = 0; b_addr = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if ({a_gnt, b_gnt} !== 2'b01) begin
        n_fail++;
        $display("FAIL b_only[%0d] got %b%b want 01", i, a_gnt, b_gnt);
      end
      issue(0, 1);
      @(posedge clk); #1;
    end
    a_req = 1; a_we = 0; a_addr = 1;
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL a_first got %b%b want 10", a_gnt, b_gnt);
    end
    issue(1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL b_next got %b%b want 01", a_gnt, b_gnt);
    end
    issue(0, 1);
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    a_req = 1; a_we = 0; a_addr = 3;
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL pre_clear_read got %b%b want 10", a_gnt, b_gnt);
    end
    issue(1, 0);
    @(posedge clk); #1;
    b_req = 1; b_we = 0; b_addr = 3; clr_start = 1;
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt, busy, mem_wr_enb, mem_rd_enb} !== 5'b0) begin
      n_fail++;
      $display("FAIL clr_start_cycle got gnt=%b%b busy=%b wr=%b rd=%b want 0",
               a_gnt, b_gnt, busy, mem_wr_enb, mem_rd_enb);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_chk++;
      if ({a_gnt, b_gnt, busy, clr_done, mem_wr_enb, mem_rd_enb,
           mem_wr_addr, mem_data_in} !==
          {2'b00, 1'b1, (i == 7), 2'b10, 3'(i), 8'h00}) begin
        n_fail++;
        $display("FAIL clear[%0d] got gnt=%b%b busy=%b done=%b wr=%b rd=%b wa=%0d wd=%h",
                 i, a_gnt, b_gnt, busy, clr_done, mem_wr_enb, mem_rd_enb,
                 mem_wr_addr, mem_data_in);
      end
      ref_mem[i] = '0;
      @(posedge clk); #1;
      clr_start = 0;
    end
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt, busy, clr_done} !== 4'b0100) begin
      n_fail++;
      $display("FAIL post_clear got gnt=%b%b busy=%b done=%b want 01 0 0",
               a_gnt, b_gnt, busy, clr_done);
    end
    issue(0, 1);
    @(posedge clk); #1;
    b_req = 0;
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_clear_a got %b%b want 10", a_gnt, b_gnt);
    end
    issue(1, 0);
    @(posedge clk); #1;
    a_req = 0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_rvalid();
    a_req = 1; a_we = 1; a_addr = 6; a_wdata = 8'h77;
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL w77 got %b%b want 10", a_gnt, b_gnt);
    end
    issue(1, 0);
    @(posedge clk); #1;
    a_we = 0;
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL r77 got %b%b want 10", a_gnt, b_gnt);
    end
    @(posedge clk); #1;
    n_chk++;
    if (a_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rvalid_before_rst got %b want 1", a_rvalid);
    end
    rst_n = 0; a_req = 0;
    #1;
    n_chk++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL rst_cancels_rvalid got %h want 0", outs());
    end
    sb.delete();
    @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_clear();
    clr_start = 1;
    @(negedge clk);
    @(posedge clk); #1;
    clr_start = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ref_mem[i] = '0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || mem_wr_addr !== 3'd4) begin
      n_fail++;
      $display("FAIL mid_clear got busy=%b wa=%0d want 1 4", busy, mem_wr_addr);
    end
    rst_n = 0; a_req = 1; a_we = 0; a_addr = 6;
    #1;
    n_chk++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_clear got %h want 0", outs());
    end
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL rst_hold_clear got %h want 0", outs());
    end
    @(posedge clk);
    #2 rst_n = 1;
    sb.delete();
    @(negedge clk);
    n_chk++;
    if ({a_gnt, b_gnt, busy, clr_done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL arb_after_rst got gnt=%b%b busy=%b done=%b want 10 0 0",
               a_gnt, b_gnt, busy, clr_done);
    end
    issue(1, 0);
    @(posedge clk); #1;
    a_req = 0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_write_read();
    do_reset();
    test_alternate();
    test_b_write_a_read();
    test_starve();
    test_clear();
    test_reset_rvalid();
    test_reset_mid_clear();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_reads got %0d want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 3, memory address width (8 entries).
REQ-002 Parameter: DATA_W, 8, memory data width.
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: a_req / b_req  input  1  client A/B request.
REQ-006 Port: a_we / b_we  input  1  1 = write, 0 = read; qualified by req.
REQ-007 Port: a_addr / b_addr  input  ADDR_W  client address.
REQ-008 Port: a_wdata / b_wdata  input  DATA_W  client write data.
REQ-009 Port: a_gnt / b_gnt  output  1  request accepted this cycle.
REQ-010 Port: a_rvalid / b_rvalid  output  1  read data valid for this client.
REQ-011 Port: rdata  output  DATA_W  read data, shared by both clients, qualified by a_rvalid / b_rvalid.
REQ-012 Port: clr_start  input  1  pulse, zero-fill the whole memory.
REQ-013 Port: busy  output  1  clear sequence in progress.
REQ-014 Port: clr_done  output  1  one-cycle pulse at end of clear.
REQ-015 Port: mem_wr_enb, mem_wr_addr[ADDR_W], mem_data_in[DATA_W], mem_rd_enb, mem_rd_addr[ADDR_W]  output  memory port controls.
REQ-016 Port: mem_data_out  input  DATA_W  memory registered read data, 1-cycle latency.

Function
REQ-017 FSM states: ARB (serve clients) and CLEAR (zero-fill); reset state ARB.
REQ-018 ARB: at most one grant per cycle; a transfer occurs when req & gnt in the same cycle; gnt is combinational from req and the priority pointer.
REQ-019 Round-robin: a single requester is always granted; if both request, grant the client not granted most recently; the pointer updates only on a transfer.
REQ-020 A granted write drives mem_wr_enb=1 with the client's addr/wdata in the same cycle; the memory is updated at that edge.
REQ-021 A granted read drives mem_rd_enb=1, mem_rd_addr=addr; the matching a_rvalid/b_rvalid is asserted exactly one cycle later; rdata = mem_data_out in that cycle.
REQ-022 A read granted in the cycle after a write to the same address returns the new data.
REQ-023 Clients hold req, we, addr and wdata stable until granted; an ungranted request has no side effects.
REQ-024 clr_start in ARB: no grant that cycle; next state CLEAR; clr_start in CLEAR is ignored.
REQ-025 CLEAR: write 0 to addresses 0..7 in ascending order, one per cycle (8 cycles); busy=1 and all gnt=0 throughout.
REQ-026 On the cycle writing address 7, assert clr_done=1 and return to ARB on the next edge; a pending request is granted on the first ARB cycle.
REQ-027 A read granted on the cycle clr_start is sampled still produces its rvalid one cycle later.
REQ-028 mem_* outputs are 0 when no operation is issued.

Reset
REQ-029 rst_n=0 immediately forces: state ARB, pointer favours A, gnt/rvalid/busy/clr_done/mem_wr_enb/mem_rd_enb = 0, clear counter = 0, rdata = 0.
REQ-030 Reset during CLEAR aborts the sequence; memory contents are not guaranteed; no clr_done is issued.
REQ-031 Reset during a read cancels the pending rvalid.

Structure
REQ-032 Shared package holds ADDR_W, DATA_W defaults and the FSM state enum (ARB, CLEAR).
REQ-033 Round-robin grant logic is one sub-module, rr_arb2 (2 requesters, last-grant pointer).
REQ-034 Memory is external; in the top level it is connected to the team's 8x8 RAM with rst driven by !rst_n.

Verification
REQ-035 A writes 0x5A @3, then A reads @3 -> a_gnt each cycle; a_rvalid one cycle after the read grant with rdata=0x5A.
REQ-036 A and B request continuously (reads @1, @2) -> grants alternate A,B,A,B; each rvalid goes only to the owner.
REQ-037 B writes 0xC3 @6; next cycle A reads @6 -> rdata=0xC3.
REQ-038 clr_start with both requesting -> busy for 8 cycles, no gnt, mem writes 0 @0..7, clr_done on the 8th cycle; reading @3 afterwards returns 0x00.
REQ-039 rst_n low mid-CLEAR at address 4 -> all outputs 0 immediately, no clr_done, ARB after release.
REQ-040 Only B requests for 5 cycles -> b_gnt every cycle, no starvation; then A+B -> A granted first.
